fir_mac_ctrl: RTL and testbench
===============================

// Module: fir_mac_ctrl
// PURPOSE
//  Downstream consumer of the 32-entry sample shift register in the FIR path.
//  Per new input sample it pulses nowa_shift, sweeps adres 0..N_TAPS-1, and
//  multiplies each tap sample by the matching coefficient from coefficient memory.
//  It accumulates, rounds and saturates to one Q15 output sample with a valid pulse.
// PARAMETERS
//  N_TAPS     32  taps per output; adres/coef_adres range 0..N_TAPS-1
//  DATA_W     16  sample width, signed Q15
//  COEF_W     16  coefficient width, signed Q15
//  ACC_W      40  accumulator width, signed
//  FRAC_BITS  15  fractional bits removed at rounding
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  start        in   1       new sample ready; sampled only when busy==0
//  flush        in   1       clear history; sampled only when busy==0
//  busy         out  1       high from SHIFT through DONE inclusive
//  nowa_shift   out  1       one-cycle pulse: shift register loads next sample
//  reset_shift  out  1       one-cycle pulse: shift register clears
//  adres        out  5       tap address to shift register (registered read, 1-cycle latency)
//  probka_tap   in   DATA_W  shift register output for adres issued previous cycle
//  coef_adres   out  5       coefficient memory address (1-cycle read latency)
//  coef_in      in   COEF_W  coefficient for coef_adres issued previous cycle
//  result       out  DATA_W  filtered sample, held until next result_valid
//  result_valid out  1       one-cycle pulse, result updated same cycle
//  overrun      out  1       one-cycle pulse: start seen while busy==1 (start dropped)
// BEHAVIOUR
//  Reset: state IDLE, acc=0, tap counter=0.
//   All outputs 0: busy, nowa_shift, reset_shift, adres, coef_adres, result, result_valid, overrun.
//  FSM: IDLE -> SHIFT -> MAC -> DRAIN -> ROUND -> DONE -> IDLE.
//  IDLE
//   - flush=1: reset_shift=1 next cycle, stay IDLE.
//   - flush=1 and start=1 together: flush wins, start dropped, no overrun.
//   - start=1 (flush=0): go to SHIFT.
//  SHIFT, 1 cycle: nowa_shift=1; acc cleared to 0; adres=coef_adres=0.
//  MAC, N_TAPS cycles: adres=coef_adres=k for k=0..N_TAPS-1, k increments each cycle.
//  Datapath pipeline:
//   - Cycle after issue: probka_tap/coef_in valid; signed product registered (DATA_W+COEF_W bits).
//   - Cycle after that: product sign-extended to ACC_W and added to acc.
//  DRAIN, 2 cycles: last two products enter acc; adres holds N_TAPS-1.
//  ROUND, 1 cycle: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift.
//   r saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; result <= saturated r.
//  DONE, 1 cycle: result_valid=1, busy=1; then IDLE.
//  Latency: start sampled in cycle 0 -> result_valid in cycle N_TAPS+5 (37).
//  Throughput: next start accepted in cycle N_TAPS+6.
//  Overrun: start=1 while busy=1 -> overrun=1 next cycle; current computation unaffected.
//  flush while busy is ignored; no reset_shift is generated.
//  ACC_W=40 cannot overflow for N_TAPS<=256; no wrap handling needed.
//  rst mid-operation: abort at next edge, no result_valid, result returns to 0.
//  adres/coef_adres never exceed N_TAPS-1, no wrap.
// STRUCTURE
//  Package fir_pkg:
//   - constants N_TAPS, DATA_W, COEF_W, ACC_W, FRAC_BITS
//   - typedef sample_t, coef_t, acc_t
//   - enum mac_state_t {IDLE,SHIFT,MAC,DRAIN,ROUND,DONE}
//   - function sat_round(acc_t) -> sample_t
//  Sub-module fir_mac_dp: product register, accumulator, round/saturate, result register.
//   Controlled by clr_acc, en_mul, en_acc, en_round from the FSM.
//  fir_mac_ctrl holds the FSM, tap counter, address and pulse generation.
// TESTING (bench models shift register and coef memory with 1-cycle registered reads)
//  1 Impulse: flush; sample 0x7FFF then zeros; coef[k]=k*256.
//    -> outputs k*256 scaled ((0x7FFF*k*256+2^14)>>15) for k=0..31, one per start.
//  2 Latency: start at cycle 0.
//    -> nowa_shift in cycle 1; adres 0..31 in cycles 2..33; result_valid only in cycle 37.
//  3 Saturation: all taps 0x7FFF, all coefs 0x7FFF -> result 0x7FFF.
//    All taps 0x8000, coefs 0x7FFF -> result 0x8000.
//  4 Rounding: single tap 1, coef 0x4000 -> acc 0x4000 -> result 1 (half rounds up).
//    Tap -1, coef 0x4000 -> result 0.
//  5 Overrun/flush: start in cycle 5 of a run -> overrun pulse, one result_valid only.
//    flush+start in IDLE -> reset_shift pulse, no nowa_shift.
//  6 rst asserted in cycle 20 -> busy=0, result=0 next cycle, no result_valid.
//    Next start gives correct result.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR MAC types, widths and the round/saturate helper.
// Pure declarations: no latency, no flow control.
package fir_pkg;

  localparam int N_TAPS    = 32;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int ACC_W     = 40;
  localparam int FRAC_BITS = 15;
  localparam int ADDR_W    = $clog2(N_TAPS);
  localparam int PROD_W    = DATA_W + COEF_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic [ADDR_W-1:0]        addr_t;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    MAC,
    DRAIN,
    ROUND,
    DONE
  } mac_state_t;

  localparam addr_t TAP_LAST = addr_t'(N_TAPS - 1);
  localparam acc_t  SAT_MAX  = acc_t'((2 ** (DATA_W - 1)) - 1);
  localparam acc_t  SAT_MIN  = -acc_t'(2 ** (DATA_W - 1));
  localparam acc_t  RND_HALF = acc_t'(2 ** (FRAC_BITS - 1));

  // Round half up (toward +inf) before dropping the fraction, then clamp to Q15.
  function automatic sample_t sat_round(input acc_t acc);
    acc_t r;
    r = (acc + RND_HALF) >>> FRAC_BITS;
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end
    return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_ctrl_if.sv
// Bundle between the MAC controller and the sample shift register / coefficient memory.
// Wiring only: no latency; no backpressure, start is dropped (overrun) while busy.
interface fir_mac_ctrl_if;
  import fir_pkg::*;

  logic    start;
  logic    flush;
  logic    busy;
  logic    nowa_shift;
  logic    reset_shift;
  addr_t   adres;
  sample_t probka_tap;
  addr_t   coef_adres;
  coef_t   coef_in;
  sample_t result;
  logic    result_valid;
  logic    overrun;

  modport slave (
    input  start, flush, probka_tap, coef_in,
    output busy, nowa_shift, reset_shift, adres, coef_adres,
           result, result_valid, overrun
  );

  modport master (
    output start, flush, probka_tap, coef_in,
    input  busy, nowa_shift, reset_shift, adres, coef_adres,
           result, result_valid, overrun
  );

endinterface

// File: rtl/fir_mac_dp.sv
// MAC datapath: product register, 40-bit accumulator, round/saturate into the result register.
// Two-stage multiply/accumulate pipeline steered by FSM enables; no backpressure.
module fir_mac_dp
  import fir_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clr_acc,
  input  logic    en_mul,
  input  logic    en_acc,
  input  logic    en_round,
  input  sample_t tap_in,
  input  coef_t   coef_in,
  output sample_t result
);

  prod_t   prod_q, prod_d;
  acc_t    acc_q, acc_d;
  sample_t result_q, result_d;

  always_comb begin
    prod_d   = prod_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (en_mul) begin
      prod_d = prod_t'(tap_in) * prod_t'(coef_in);
    end
    if (clr_acc) begin
      acc_d = '0;
    end else if (en_acc) begin
      acc_d = acc_q + acc_t'(prod_q);
    end
    if (en_round) begin
      result_d = sat_round(acc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR MAC sequencer: one shift pulse, a 0..N_TAPS-1 tap sweep, then one rounded Q15 result.
// start -> result_valid in N_TAPS+5 cycles; start while busy is dropped and flagged as overrun.
module fir_mac_ctrl
  import fir_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fir_mac_ctrl_if.slave  bus
);

  mac_state_t state_q, state_d;
  addr_t      tap_q, tap_d;
  logic       drain_q, drain_d;
  logic       mul_vld_q, mul_vld_d;
  logic       acc_vld_q, acc_vld_d;
  logic       reset_shift_q, reset_shift_d;
  logic       overrun_q, overrun_d;
  logic       busy;

  always_comb begin
    state_d       = state_q;
    tap_d         = tap_q;
    drain_d       = drain_q;
    reset_shift_d = 1'b0;
    busy          = (state_q != IDLE);
    overrun_d     = busy && bus.start;
    // Read data returns one cycle after issue, the product lands one cycle later.
    mul_vld_d     = (state_q == MAC);
    acc_vld_d     = mul_vld_q;

    unique case (state_q)
      IDLE: begin
        if (bus.flush) begin
          reset_shift_d = 1'b1;
        end else if (bus.start) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        tap_d   = '0;
        drain_d = 1'b0;
        state_d = MAC;
      end
      MAC: begin
        if (tap_q == TAP_LAST) begin
          state_d = DRAIN;
        end else begin
          tap_d = tap_q + addr_t'(1);
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d = DONE;
      end
      DONE: begin
        tap_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tap_q         <= '0;
      drain_q       <= 1'b0;
      mul_vld_q     <= 1'b0;
      acc_vld_q     <= 1'b0;
      reset_shift_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap_d;
      drain_q       <= drain_d;
      mul_vld_q     <= mul_vld_d;
      acc_vld_q     <= acc_vld_d;
      reset_shift_q <= reset_shift_d;
      overrun_q     <= overrun_d;
    end
  end

  fir_mac_dp u_dp (
    .clk      (clk),
    .rst      (rst),
    .clr_acc  (state_q == SHIFT),
    .en_mul   (mul_vld_q),
    .en_acc   (acc_vld_q),
    .en_round (state_q == ROUND),
    .tap_in   (bus.probka_tap),
    .coef_in  (bus.coef_in),
    .result   (bus.result)
  );

  assign bus.busy         = busy;
  assign bus.nowa_shift   = (state_q == SHIFT);
  assign bus.reset_shift  = reset_shift_q;
  assign bus.adres        = tap_q;
  assign bus.coef_adres   = tap_q;
  assign bus.result_valid = (state_q == DONE);
  assign bus.overrun      = overrun_q;

  a_adres_range : assert property (@(posedge clk) disable iff (rst) bus.adres <= TAP_LAST);
  a_pulse_excl  : assert property (@(posedge clk) disable iff (rst) !(bus.nowa_shift && bus.reset_shift));
  a_valid_busy  : assert property (@(posedge clk) disable iff (rst) bus.result_valid |-> bus.busy);

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Bench for fir_mac_ctrl: shift register and coefficient memory models with registered reads,
// a sample-history reference model checked every cycle, plus hand-computed spot checks.
module tb_fir_mac_ctrl;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_ctrl_if ifc ();

  fir_mac_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int tests  = 0;
  int fails  = 0;
  int nprint = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: 32-entry sample shift register and coefficient memory.
  logic [15:0] sr   [32];
  logic [15:0] cmem [32];
  logic [15:0] new_sample;

  always @(posedge clk) begin
    ifc.probka_tap <= sr[ifc.adres];
    ifc.coef_in    <= cmem[ifc.coef_adres];
    if (ifc.reset_shift) begin
      for (int i = 0; i < 32; i++) sr[i] <= '0;
    end else if (ifc.nowa_shift) begin
      for (int i = 31; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= new_sample;
    end
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (nprint < 30) begin
        nprint++;
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
    end
  endtask

  // Reference model: history of accepted samples, newest first.
  logic signed [15:0] hist [32];
  int          st_cyc   = -1000;
  int          fl_cyc   = -1000;
  int          ov_cyc   = -1000;
  logic [15:0] res_hold = '0;
  logic [15:0] pending  = '0;

  function automatic logic [15:0] model_result();
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < 32; k++) acc += longint'(hist[k]) * longint'($signed(cmem[k]));
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  always @(negedge clk) begin : cmp
    int off;
    int exp_adr;
    bit mb;
    if (chk_en) begin
      off = cyc - st_cyc;
      mb  = (off >= 1 && off <= 37);
      if (off == 37) res_hold = pending;
      chk("busy",         40'(ifc.busy),         40'(mb));
      chk("nowa_shift",   40'(ifc.nowa_shift),   40'(off == 1));
      chk("result_valid", 40'(ifc.result_valid), 40'(off == 37));
      chk("result",       40'($unsigned(ifc.result)), 40'(res_hold));
      chk("reset_shift",  40'(ifc.reset_shift),  40'(cyc == fl_cyc + 1));
      chk("overrun",      40'(ifc.overrun),      40'(cyc == ov_cyc + 1));
      if (off >= 1 && off <= 35) begin
        exp_adr = (off <= 1) ? 0 : (off <= 33) ? off - 2 : 31;
        chk("adres",      40'(ifc.adres),      40'(exp_adr));
        chk("coef_adres", 40'(ifc.coef_adres), 40'(exp_adr));
      end
      if (rst) begin
        st_cyc   = -1000;
        fl_cyc   = -1000;
        ov_cyc   = -1000;
        res_hold = '0;
      end else if (ifc.start && mb) begin
        ov_cyc = cyc;
      end else if (ifc.flush && !mb) begin
        fl_cyc = cyc;
        for (int k = 0; k < 32; k++) hist[k] = '0;
      end else if (ifc.start && !mb) begin
        st_cyc = cyc;
        for (int k = 31; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = new_sample;
        pending = model_result();
      end
    end
  end

  task automatic flush_idle(input bit with_start);
    @(posedge clk); #1;
    ifc.flush = 1'b1;
    ifc.start = with_start;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    ifc.start = 1'b0;
    @(negedge clk);
    chk("flush_reset_shift", 40'(ifc.reset_shift), 40'd1);
    chk("flush_no_nowa",     40'(ifc.nowa_shift),  40'd0);
  endtask

  task automatic run(input logic [15:0] s, input int ov_off, input int fl_off, input int rst_off,
                     output logic [15:0] r, output int lat, output int nv, output int nov);
    int t0;
    r   = '0;
    lat = -1;
    nv  = 0;
    nov = 0;
    @(posedge clk); #1;
    new_sample = s;
    ifc.start  = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      ifc.start = (i == ov_off);
      ifc.flush = (i == fl_off);
      rst       = (i == rst_off);
      @(negedge clk);
      if (ifc.result_valid) begin
        nv++;
        r   = ifc.result;
        lat = cyc - t0;
      end
      if (ifc.overrun) nov++;
      if (rst_off > 0 && i == rst_off + 1) begin
        chk("rst_busy",   40'(ifc.busy), 40'd0);
        chk("rst_result", 40'($unsigned(ifc.result)), 40'd0);
      end
    end
  endtask

  initial begin
    logic [15:0] r;
    int lat, nv, nov, ov, fl;
    logic [15:0] s;
    ifc.start  = 1'b0;
    ifc.flush  = 1'b0;
    new_sample = '0;
    for (int k = 0; k < 32; k++) begin
      cmem[k] = '0;
      hist[k] = '0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",         40'(ifc.busy),         40'd0);
    chk("reset_nowa",         40'(ifc.nowa_shift),   40'd0);
    chk("reset_reset_shift",  40'(ifc.reset_shift),  40'd0);
    chk("reset_adres",        40'(ifc.adres),        40'd0);
    chk("reset_coef_adres",   40'(ifc.coef_adres),   40'd0);
    chk("reset_result",       40'($unsigned(ifc.result)), 40'd0);
    chk("reset_result_valid", 40'(ifc.result_valid), 40'd0);
    chk("reset_overrun",      40'(ifc.overrun),      40'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Impulse response with coef[k] = k*256: output n equals n*256.
    flush_idle(1'b0);
    for (int k = 0; k < 32; k++) cmem[k] = 16'(k * 256);
    for (int n = 0; n < 32; n++) begin
      run((n == 0) ? 16'h7FFF : 16'h0000, 0, 0, 0, r, lat, nv, nov);
      chk("impulse_out", 40'(r), 40'(n * 256));
      chk("impulse_nvalid", 40'(nv), 40'd1);
      if (n == 0) chk("latency", 40'(lat), 40'd37);
    end

    // Saturation at both rails.
    flush_idle(1'b0);
    for (int k = 0; k < 32; k++) cmem[k] = 16'h7FFF;
    for (int n = 0; n < 32; n++) run(16'h7FFF, 0, 0, 0, r, lat, nv, nov);
    chk("sat_pos", 40'(r), 40'h7FFF);
    flush_idle(1'b0);
    for (int n = 0; n < 32; n++) run(16'h8000, 0, 0, 0, r, lat, nv, nov);
    chk("sat_neg", 40'(r), 40'h8000);

    // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds to zero.
    flush_idle(1'b0);
    for (int k = 0; k < 32; k++) cmem[k] = '0;
    cmem[0] = 16'h4000;
    run(16'h0001, 0, 0, 0, r, lat, nv, nov);
    chk("round_half_up", 40'(r), 40'h1);
    run(16'hFFFF, 0, 0, 0, r, lat, nv, nov);
    chk("round_neg_half", 40'(r), 40'h0);

    // Overrun in cycle 5 and a flush while busy: one result, one overrun pulse.
    for (int k = 0; k < 32; k++) cmem[k] = 16'(k * 97 + 3);
    run(16'h1234, 5, 9, 0, r, lat, nv, nov);
    chk("overrun_nvalid", 40'(nv), 40'd1);
    chk("overrun_pulses", 40'(nov), 40'd1);
    flush_idle(1'b1);

    // Reset mid-run, then a clean run afterwards.
    run(16'h0F00, 0, 0, 20, r, lat, nv, nov);
    chk("rst_nvalid", 40'(nv), 40'd0);
    run(16'h0100, 0, 0, 0, r, lat, nv, nov);
    chk("after_rst_nvalid", 40'(nv), 40'd1);

    // Randomized runs.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(3) == 0)
        for (int k = 0; k < 32; k++) cmem[k] = 16'($urandom);
      if ($urandom_range(4) == 0) flush_idle(1'($urandom_range(1)));
      repeat ($urandom_range(3)) @(posedge clk);
      ov = ($urandom_range(2) == 0) ? int'($urandom_range(37, 2)) : 0;
      fl = ($urandom_range(3) == 0) ? int'($urandom_range(36, 2)) : 0;
      case ($urandom_range(3))
        0:       s = 16'h7FFF;
        1:       s = 16'h8000;
        default: s = 16'($urandom);
      endcase
      run(s, ov, fl, 0, r, lat, nv, nov);
      chk("rand_nvalid", 40'(nv), 40'd1);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
